dcache_dm_wb: RTL and testbench

//  Parametrised direct-mapped, write-back, write-allocate data cache between the core LSU and the

---
 rtl/dcache_dm_wb.sv | 152 +++++++++++++++
 tb/tb_dcache_dm_wb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the LSU and a line-wide memory port.
// Optional hit/miss/writeback counters are enabled by defining DCACHE_STATS_EN.
module dcache_dm_wb #(
  parameter int NLINES    = 4,
  parameter int LINE_BITS = 128,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [WORD_W-1:0]     cpu_wdata,
  input  logic [WORD_W/8-1:0]   cpu_be,
  output logic                  cpu_ack,
  output logic [WORD_W-1:0]     cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [LINE_BITS-1:0]  mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_BITS-1:0]  mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_wbs
`endif
);

  localparam int OFF    = $clog2(LINE_BITS / 8);
  localparam int IDX    = $clog2(NLINES);
  localparam int TAG    = ADDR_W - OFF - IDX;
  localparam int BSEL   = $clog2(WORD_W / 8);
  localparam int WSEL   = OFF - BSEL;
  localparam int NBYTES = WORD_W / 8;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t state, state_nxt;

  logic [LINE_BITS-1:0] data_mem [NLINES];
  logic [TAG-1:0]       tag_mem  [NLINES];
  logic [NLINES-1:0]    valid_q, dirty_q;

  logic [IDX-1:0]       req_idx;
  logic [TAG-1:0]       req_tag;
  logic [WSEL-1:0]      word_sel;
  logic                 hit;
  logic [LINE_BITS-1:0] cur_line, merged_line;
  logic [WORD_W-1:0]    cur_word;
  logic                 unused_addr_bits;

  assign req_idx          = cpu_addr[OFF +: IDX];
  assign req_tag          = cpu_addr[ADDR_W-1 -: TAG];
  assign word_sel         = cpu_addr[BSEL +: WSEL];
  assign unused_addr_bits = ^cpu_addr[BSEL-1:0];

  assign cur_line  = data_mem[req_idx];
  assign cur_word  = cur_line[int'(word_sel)*WORD_W +: WORD_W];
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign mem_wdata = cur_line;

  always_comb begin
    merged_line = cur_line;
    for (int b = 0; b < NBYTES; b++) begin
      if (cpu_be[b]) merged_line[int'(word_sel)*WORD_W + b*8 +: 8] = cpu_wdata[b*8 +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (hit)                                       state_nxt = RESP;
          else if (valid_q[req_idx] && dirty_q[req_idx]) state_nxt = WB;
          else                                           state_nxt = FILL;
        end
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_mem[req_idx], req_idx, {OFF{1'b0}}};
        if (mem_ready) state_nxt = FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {OFF{1'b0}}};
        if (mem_ready) state_nxt = RESP;
      end
      RESP: begin
        cpu_ack   = 1'b1;
        cpu_rdata = cur_word;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ready) begin
      data_mem[req_idx] <= mem_rdata;
      tag_mem[req_idx]  <= req_tag;
    end else if (state == RESP && cpu_we) begin
      data_mem[req_idx] <= merged_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state == FILL && mem_ready) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (state == RESP && cpu_we) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
    end else begin
      if (state == IDLE && cpu_req) begin
        if (hit && stat_hits != 32'hFFFF_FFFF)          stat_hits   <= stat_hits + 32'd1;
        else if (!hit && stat_misses != 32'hFFFF_FFFF)  stat_misses <= stat_misses + 32'd1;
      end
      if (state == WB && mem_ready && stat_wbs != 32'hFFFF_FFFF) stat_wbs <= stat_wbs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Scoreboard bench for dcache_dm_wb: stimulus queues expected CPU and memory responses,
// a monitor compares them whenever the DUT acks or completes a memory transfer.
module tb_dcache_dm_wb;

  localparam int ADDR_W = 20, WORD_W = 32, LINE_BITS = 128, MEM_LAT = 1;

  localparam logic [127:0] LINE_100 = 128'hA0030003_A0020002_A0010001_A0000000;
  localparam logic [127:0] LINE_140 = 128'hB0030003_B0020002_B0010001_B0000000;
  localparam logic [127:0] MERGED   = 128'hA0030003_A002BEEF_A0010001_A0000000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cpu_req, cpu_we;
  logic [ADDR_W-1:0]    cpu_addr;
  logic [WORD_W-1:0]    cpu_wdata;
  logic [3:0]           cpu_be;
  logic                 cpu_ack;
  logic [WORD_W-1:0]    cpu_rdata;
  logic                 mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0]    mem_addr;
  logic [LINE_BITS-1:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]          stat_hits, stat_misses, stat_wbs;
`endif

  always #5 clk = ~clk;

  dcache_dm_wb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
`endif
  );

  typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [LINE_BITS-1:0] wdata; } mem_exp_t;
  typedef struct { logic chk; logic [WORD_W-1:0] rdata; } cpu_exp_t;

  mem_exp_t mem_q[$];
  cpu_exp_t cpu_q[$];
  mem_exp_t me;
  cpu_exp_t ce;
  int checks = 0, errors = 0;

  logic [LINE_BITS-1:0] mem_model [logic [ADDR_W-1:0]];
  logic mem_hold = 1'b0;
  int   wait_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: answers each request after MEM_LAT idle cycles unless held.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_req && rst_n && !mem_hold) begin
        if (wait_cnt < MEM_LAT) wait_cnt++;
        else begin
          wait_cnt  = 0;
          mem_ready = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares every completed memory transfer and every CPU ack against the queues.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && mem_req && mem_ready) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected: got transfer we=%b addr=%h, expected none", mem_we, mem_addr);
        end else begin
          me = mem_q.pop_front();
          check("mem_we", 128'(mem_we), 128'(me.we));
          check("mem_addr", 128'(mem_addr), 128'(me.addr));
          if (me.we) check("mem_wdata", mem_wdata, me.wdata);
        end
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_unexpected_ack: got ack addr=%h, expected none", cpu_addr);
        end else begin
          ce = cpu_q.pop_front();
          if (ce.chk) check("cpu_rdata", 128'(cpu_rdata), 128'(ce.rdata));
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [ADDR_W-1:0] addr, input logic [LINE_BITS-1:0] wdata);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    mem_q.push_back(e);
  endtask

  // exp_lat = 0 means latency is not checked for this operation.
  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] wdata,
                        input logic [3:0] be, input logic chk, input logic [WORD_W-1:0] exp_rdata,
                        input int exp_lat);
    cpu_exp_t e;
    int lat;
    e.chk = chk; e.rdata = exp_rdata;
    cpu_q.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    lat = 0;
    do begin
      @(negedge clk);
      #2;
      lat++;
    end while (!cpu_ack && lat < 200);
    if (!cpu_ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack for addr %h after %0d cycles, expected ack", addr, lat);
    end else if (exp_lat != 0) begin
      check("ack_latency", 128'(lat), 128'(exp_lat));
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem_model[20'h00100] = LINE_100;
    mem_model[20'h00140] = LINE_140;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_cpu_ack", 128'(cpu_ack), 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_cpu_rdata", 128'(cpu_rdata), 128'(0));
    rst_n = 1'b1;

    // Cold load miss, then hits within the same line.
    push_mem(1'b0, 20'h00100, '0);
    cpu_op(1'b0, 20'h00100, '0, 4'h0, 1'b1, 32'hA000_0000, 0);
    cpu_op(1'b0, 20'h00104, '0, 4'h0, 1'b1, 32'hA001_0001, 1);

    // Partial store hit, then read back the merged word.
    cpu_op(1'b1, 20'h00108, 32'hDEAD_BEEF, 4'b0011, 1'b0, '0, 1);
    cpu_op(1'b0, 20'h00108, '0, 4'h0, 1'b1, 32'hA002_BEEF, 1);

    // Conflict miss on a dirty line: writeback of the merged line, then refill.
    push_mem(1'b1, 20'h00100, MERGED);
    push_mem(1'b0, 20'h00140, '0);
    cpu_op(1'b0, 20'h00140, '0, 4'h0, 1'b1, 32'hB000_0000, 0);
`ifdef DCACHE_STATS_EN
    check("stat_hits", 128'(stat_hits), 128'(3));
    check("stat_misses", 128'(stat_misses), 128'(2));
    check("stat_wbs", 128'(stat_wbs), 128'(1));
`endif
    cpu_op(1'b0, 20'h0014C, '0, 4'h0, 1'b1, 32'hB003_0003, 1);

    // Reset while a refill is stalled on memory.
    mem_hold = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00100;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!mem_req && n < 20);
    check("stall_mem_req", 128'(mem_req), 128'(1));
    check("stall_mem_addr", 128'(mem_addr), 128'(20'h00100));
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    #2;
    check("rst_mid_fill_mem_req", 128'(mem_req), 128'(0));
    rst_n = 1'b1; mem_hold = 1'b0;
    push_mem(1'b0, 20'h00100, '0);
    cpu_op(1'b0, 20'h00100, '0, 4'h0, 1'b1, 32'hA000_0000, 0);
    cpu_op(1'b0, 20'h00108, '0, 4'h0, 1'b1, 32'hA002_BEEF, 1);

    // Zero byte-enable store: data unchanged but the line still becomes dirty.
    cpu_op(1'b1, 20'h00104, 32'hFFFF_FFFF, 4'b0000, 1'b0, '0, 1);
    cpu_op(1'b0, 20'h00104, '0, 4'h0, 1'b1, 32'hA001_0001, 1);
    push_mem(1'b1, 20'h00100, MERGED);
    push_mem(1'b0, 20'h00140, '0);
    cpu_op(1'b0, 20'h00144, '0, 4'h0, 1'b1, 32'hB001_0001, 0);

    // Store miss on a clean victim: refill only, then merge.
    push_mem(1'b0, 20'h00180, '0);
    cpu_op(1'b1, 20'h00184, 32'h1234_5678, 4'b1111, 1'b0, '0, 0);
    cpu_op(1'b0, 20'h00184, '0, 4'h0, 1'b1, 32'h1234_5678, 1);
    cpu_op(1'b0, 20'h00180, '0, 4'h0, 1'b1, 32'h0000_0000, 1);

    repeat (4) @(negedge clk);
    check("mem_q_drained", 128'(mem_q.size()), 128'(0));
    check("cpu_q_drained", 128'(cpu_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
